// File: rtl/mux_alu_b_if.sv
// mux_alu_b_if: ALU operand-B selector signal bundle (select, sources, load enable, results).
interface mux_alu_b_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       seletor;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [WIDTH-1:0] F;
    logic             en;
    logic [WIDTH-1:0] F_q;

    modport master (output seletor, I1, I2, I3, en, input F, F_q);
    modport slave  (input seletor, I1, I2, I3, en, output F, F_q);
endinterface

// File: rtl/mux_alu_b.sv
// mux_alu_b: ALU operand-B source selector with combinational output F and enabled register copy F_q.
module mux_alu_b #(
    parameter int          WIDTH     = 32,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic [1:0]       seletor,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [WIDTH-1:0] F,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] F_q
);
    localparam logic [WIDTH-1:0] K = WIDTH'(CONST_VAL);

    logic [WIDTH-1:0] sel_val;

    // An unknown select yields X in simulation; synthesis folds the check away and falls back to I1.
    always_comb begin
        sel_val = seletor == 2'b11 ? K : seletor == 2'b10 ? I3 : seletor == 2'b01 ? I2 : I1;
        F = (^seletor === 1'bx) ? {WIDTH{1'bx}} : sel_val;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            F_q <= '0;
        else if (en)
            F_q <= F;
    end
endmodule

// File: tb/tb_mux_alu_b.sv
// tb_mux_alu_b: directed plan plus randomized cycles against a table-lookup reference model.
module tb_mux_alu_b;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q;

    always #5 clk = ~clk;

    mux_alu_b_if #(.WIDTH(32)) bus ();

    mux_alu_b #(.WIDTH(32), .CONST_VAL(4)) dut (
        .seletor(bus.seletor),
        .I1(bus.I1),
        .I2(bus.I2),
        .I3(bus.I3),
        .F(bus.F),
        .clk(clk),
        .reset(reset),
        .en(bus.en),
        .F_q(bus.F_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_f();
        logic [31:0] src [4];
        src[0] = bus.I1;
        src[1] = bus.I2;
        src[2] = bus.I3;
        src[3] = 32'd4;
        return src[bus.seletor];
    endfunction

    // Predict the register from the values present at the edge, then compare just after it.
    task automatic tick(input string tag);
        exp_q = !reset ? 32'd0 : bus.en ? ref_f() : exp_q;
        @(posedge clk);
        #1;
        check(tag, bus.F_q, exp_q);
    endtask

    initial begin
        logic [31:0] sweep [4];
        sweep[0] = 32'd9;
        sweep[1] = 32'd7;
        sweep[2] = 32'd6;
        sweep[3] = 32'd4;
        reset = 1'b0;
        bus.en = 1'b1;
        bus.seletor = 2'b00;
        bus.I1 = 32'd9;
        bus.I2 = 32'd7;
        bus.I3 = 32'd6;
        for (int s = 0; s < 4; s++) begin
            bus.seletor = 2'(s);
            #1;
            check("sweep_f", bus.F, sweep[s]);
            #9;
        end
        bus.seletor = 2'b10;
        bus.I3 = 32'hFFFF_FFFF;
        #1;
        check("track_i3", bus.F, 32'hFFFF_FFFF);
        bus.I1 = 32'd1;
        bus.I2 = 32'd2;
        #1;
        check("track_other", bus.F, 32'hFFFF_FFFF);
        bus.I1 = 32'd9;
        bus.I2 = 32'd7;
        @(posedge clk);
        #1;
        bus.seletor = 2'b00;
        reset = 1'b0;
        bus.en = 1'b1;
        tick("rst_q1");
        check("rst_f1", bus.F, 32'd9);
        tick("rst_q2");
        check("rst_f2", bus.F, 32'd9);
        reset = 1'b1;
        bus.en = 1'b0;
        bus.seletor = 2'b01;
        tick("pre_load");
        check("pre_load_c", bus.F_q, 32'd0);
        bus.en = 1'b1;
        tick("load");
        check("load_c", bus.F_q, 32'd7);
        bus.en = 1'b0;
        bus.seletor = 2'b11;
        #1;
        check("hold_f", bus.F, 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick("hold_q");
            check("hold_c", bus.F_q, 32'd7);
        end
        bus.en = 1'b1;
        tick("load4");
        check("load4_c", bus.F_q, 32'd4);
        bus.en = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("pulse_q", bus.F_q, 32'd4);
        tick("pulse_edge");
        reset = 1'b0;
        tick("midrst");
        check("midrst_c", bus.F_q, 32'd0);
        reset = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 15) != 0);
            bus.en = 1'($urandom_range(0, 1));
            bus.seletor = 2'($urandom_range(0, 3));
            bus.I1 = $urandom;
            bus.I2 = $urandom;
            bus.I3 = $urandom;
            #1;
            check("rand_f", bus.F, ref_f());
            tick("rand_q");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
